// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks.
//   state_e : arbiter FSM encoding (ST_IDLE, ST_BURST)
//   clog2() : ceiling log2, used to size owner/pointer and burst counters
package fifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Smallest r with 2**r >= v. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i   [NREQ]  request vector
//   last_i  [PW]    index served most recently; search starts at last_i+1
//   mask_i  [NREQ]  requests to ignore (the producer being released)
//   valid_o         some unmasked request is pending
//   idx_o   [PW]    index of the first pending request after last_i, wrapping
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   last_i,
    input  logic [NREQ-1:0] mask_i,
    output logic            valid_o,
    output logic [PW-1:0]   idx_o
);

    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [NREQ-1:0] cand_req;
    logic [NREQ-1:0] hit;
    logic [PW-1:0]   cand_idx [NREQ];

    assign cand_req = req_i & ~mask_i;

    // Candidate gi is the producer gi+1 places after last_i. The sum is one
    // bit wider than an index so the wrap can be done with one subtraction.
    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [PW:0] sum;
        assign sum          = {1'b0, last_i} + (PW+1)'(gi + 1);
        assign cand_idx[gi] = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : PW'(sum);
        assign hit[gi]      = cand_req[cand_idx[gi]];
    end

    // Nearest candidate wins: scan from the far end so the closest hit is
    // the last assignment.
    always_comb begin
        valid_o = |hit;
        idx_o   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx_o = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ producers.
// One producer owns the port for at most BURST accepted words; a full FIFO
// stalls the owner without releasing it. Writes pass straight through to
// the FIFO pins.
//   clk, rst    clock, synchronous active-high reset
//   req         per-producer valid, req_data slice i holds producer i's word
//   gnt         registered one-hot owner (zero when idle)
//   ack         producer i's word is consumed this cycle
//   fifo_full   FIFO full flag
//   fifo_wr     FIFO write strobe (combinational)
//   fifo_data   owner's data slice (combinational)
//   busy        registered, high while a producer owns the port
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [WIDTH-1:0]      fifo_data,
    output logic                  busy
);

    localparam int PW = clog2(NREQ);
    localparam int CW = clog2(BURST + 1);

    state_e          state_q;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   last_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;

    logic            acc;
    logic            release_burst;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   pick_last;
    logic [NREQ-1:0] pick_oh_d;
    logic [WIDTH-1:0] slice [NREQ];

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
        assign slice[gi]     = req_data[gi*WIDTH +: WIDTH];
        assign pick_oh_d[gi] = (pick_idx == PW'(gi));
    end

    // A word in flight while reset is asserted is neither written nor acked.
    assign acc       = busy_q & req[owner_q] & ~fifo_full & ~rst;
    assign fifo_wr   = acc;
    assign ack       = gnt_q & {NREQ{acc}};
    assign fifo_data = slice[owner_q];
    assign gnt       = gnt_q;
    assign busy      = busy_q;

    // Full alone never releases: only a completed burst or a dropped request.
    assign release_burst = (acc & (cnt_q == CW'(BURST - 1))) | ~req[owner_q];

    // One picker serves both cases. In IDLE it searches after last_q with no
    // mask; in BURST it pre-computes the successor of the current owner with
    // the owner masked (gnt_q is exactly the owner's one-hot), so a release
    // can hand over without a bubble.
    assign pick_last = busy_q ? owner_q : last_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req),
        .last_i  (pick_last),
        .mask_i  (gnt_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= PW'(NREQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        gnt_q   <= pick_oh_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_BURST;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                ST_BURST: begin
                    if (release_burst) begin
                        last_q <= owner_q;
                        cnt_q  <= '0;
                        if (pick_valid) begin
                            owner_q <= pick_idx;
                            gnt_q   <= pick_oh_d;
                        end else begin
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else if (acc) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (WIDTH=8, NREQ=4, BURST=4).
// Each producer presents {id, sequence} words and advances on its ack.
// Expected (grant, data) pairs are queued as stimulus is set up and popped
// whenever the arbiter writes the FIFO.
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [WIDTH-1:0]      fifo_data;
    logic                  busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .busy      (busy)
    );

    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    logic [5:0] seq     [NREQ];
    logic [5:0] exp_seq [NREQ];
    int n_checks = 0;
    int n_errors = 0;

    logic [NREQ-1:0]  s_gnt;
    logic [NREQ-1:0]  s_ack;
    logic             s_wr;
    logic [WIDTH-1:0] s_data;
    logic             s_busy;

    function automatic logic [WIDTH-1:0] word(input int p, input logic [5:0] s);
        return {2'(p), s};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = word(i, seq[i]);
        end
    endtask

    task automatic push(input int p, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.gnt  = NREQ'(1) << p;
            e.data = word(p, exp_seq[p]);
            sb_q.push_back(e);
            exp_seq[p] = exp_seq[p] + 6'd1;
        end
    endtask

    // Everything queued so far must have been written; resync on leftovers.
    task automatic flush(input string tag);
        check_eq(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        for (int i = 0; i < NREQ; i++) exp_seq[i] = seq[i];
    endtask

    // One clock: sample at the falling edge, score any write, then let
    // producers advance just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        s_gnt  = gnt;
        s_ack  = ack;
        s_wr   = fifo_wr;
        s_data = fifo_data;
        s_busy = busy;
        if (s_wr) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_wr", 32'(s_wr), 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("wr gnt=%b ack=%b data=%h (exp gnt=%b data=%h)",
                         s_gnt, s_ack, s_data, e.gnt, e.data);
                check_eq("wr_gnt", 32'(s_gnt), 32'(e.gnt));
                check_eq("wr_ack", 32'(s_ack), 32'(e.gnt));
                check_eq("wr_data", 32'(s_data), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (s_ack[i]) seq[i] = seq[i] + 6'd1;
        end
        drive_data();
    endtask

    task automatic go_idle();
        req = '0;
        cycle();
        cycle();
        check_eq("idle_gnt", 32'(s_gnt), 32'd0);
        check_eq("idle_busy", 32'(s_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int count;
        rst       = 1'b1;
        req       = '1;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]     = '0;
            exp_seq[i] = '0;
        end
        drive_data();
        @(posedge clk);
        #1;

        // Reset held with everyone requesting
        repeat (2) begin
            cycle();
            check_eq("rst_gnt", 32'(s_gnt), 32'd0);
            check_eq("rst_wr", 32'(s_wr), 32'd0);
            check_eq("rst_busy", 32'(s_busy), 32'd0);
        end

        // Rotation: 0,1,2,3,0 with 4 words each and no bubble
        push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
        rst = 1'b0;
        cycle();
        check_eq("rel_gnt_idle", 32'(s_gnt), 32'd0);
        cycle();
        check_eq("first_gnt", 32'(s_gnt), 32'b0001);
        check_eq("first_busy", 32'(s_busy), 32'd1);
        count = 2;
        while (sb_q.size() > 0 && count < 60) begin
            cycle();
            count++;
        end
        check_eq("rot_cycles", 32'(count), 32'd21);
        flush("rot_left");
        go_idle();

        // Full stall in the middle of producer 2's burst, then sole-requester bubble
        req = 4'b0100;
        push(2, 4);
        cycle();
        check_eq("stall_wait_gnt", 32'(s_gnt), 32'd0);
        cycle();
        cycle();
        fifo_full = 1'b1;
        repeat (3) begin
            cycle();
            check_eq("stall_wr", 32'(s_wr), 32'd0);
            check_eq("stall_ack", 32'(s_ack), 32'd0);
            check_eq("stall_gnt", 32'(s_gnt), 32'b0100);
        end
        fifo_full = 1'b0;
        cycle();
        cycle();
        flush("stall_left");
        cycle();
        check_eq("sole_bubble_gnt", 32'(s_gnt), 32'd0);
        check_eq("sole_bubble_wr", 32'(s_wr), 32'd0);
        push(2, 1);
        cycle();
        check_eq("sole_regrant", 32'(s_gnt), 32'b0100);
        flush("sole_left");
        go_idle();

        // Early drop: producer 1 leaves after 2 words, producer 3 takes over
        req = 4'b0010;
        push(1, 2);
        cycle();
        check_eq("drop_wait_gnt", 32'(s_gnt), 32'd0);
        cycle();
        req = 4'b1010;
        cycle();
        req = 4'b1000;
        push(3, 4);
        cycle();
        check_eq("drop_wr", 32'(s_wr), 32'd0);
        cycle();
        check_eq("drop_next_gnt", 32'(s_gnt), 32'b1000);
        repeat (3) cycle();
        flush("drop_left");
        go_idle();

        // Leave last pointing at producer 1 so the post-reset pick is distinctive
        req = 4'b0010;
        push(1, 1);
        cycle();
        cycle();
        flush("pre_rst_left");
        go_idle();

        // Reset on the second word of producer 2's grant
        req = 4'b0100;
        push(2, 1);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_eq("midrst_wr", 32'(s_wr), 32'd0);
        check_eq("midrst_ack", 32'(s_ack), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        flush("midrst_left");
        push(0, 1);
        cycle();
        check_eq("postrst_gnt_idle", 32'(s_gnt), 32'd0);
        check_eq("postrst_busy", 32'(s_busy), 32'd0);
        cycle();
        check_eq("postrst_gnt", 32'(s_gnt), 32'b0001);
        flush("postrst_left");
        go_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
